clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Programmable clock-divider controller for the peripheral clock tree. It replaces the fixed divide-by-16 prescaler with a bus-configurable divider. Software sets the half-period, starts and stops the output, and reads back status and an edge counter. Ratio changes and stops take effect only at clkout toggle boundaries, so downstream logic never sees a runt pulse.

## Interface
- WIDTH, 16: width of half-period register, counter and edge counter.
- DEFAULT_HALF, 8: reset half-period in clkin cycles. The value 8 gives divide-by-16.

- clkin  input  1  system clock, rising-edge.
- reset  input  1  reset, asynchronous, active-low; clock clkin.
- wr_en  input  1  register write strobe, sampled on clkin rising edge.
- wr_addr  input  2  write register select.
- wr_data  input  WIDTH  write data.
- rd_addr  input  2  read register select.
- rd_data  output  WIDTH  combinational read data for rd_addr.
- clkout  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, high in the cycle after each clkout rising toggle (coincident with clkout going high).
- pending  output  1  a half-period write is waiting to be applied.

## Operation
- Register map:
  - Address 0 CTRL, write. Bit0 run. Bit1 clr_edges, self-clearing.
  - Address 1 HALF, read/write.
  - Address 2 STATUS, read only. Bit0 running (state != IDLE). Bit1 pending. Bit2 clkout. Other bits 0.
  - Address 3 EDGES, read only: count of clkout rising toggles, WIDTH bits, wraps to 0.
  - Writes to addresses 2 and 3 are ignored. Reading address 0 returns {0, run}.
- HALF write value 0 is stored as 1. Half-period 1 gives clkin/2.
- Registers:
  - active_half drives the counter.
  - shadow_half holds a pending write.
  - A HALF read returns shadow_half if pending, else active_half.
- State machine:
  - IDLE: cnt=0, clkout=0. A HALF write loads active_half directly; pending stays 0. Writing run=1 moves to RUN.
  - RUN: each cycle, if cnt==active_half-1 then cnt<=0 and clkout<=~clkout (a "toggle"); else cnt<=cnt+1.
    - Writing run=0 while clkout=0 moves to IDLE immediately; the low phase is truncated.
    - Writing run=0 while clkout=1 moves to STOPPING.
  - STOPPING: counts exactly as RUN. On the falling toggle, go to IDLE with cnt=0.
    - Writing run=1 in STOPPING returns to RUN with no change to cnt or clkout.
- HALF write while in RUN or STOPPING:
  - Stored in shadow_half; pending=1.
  - On the next toggle, active_half<=shadow_half and pending<=0.
  - The toggle in that same cycle still uses the old value.
  - A further write before the toggle overwrites shadow_half.
- HALF write in the same cycle as a toggle: treated as arriving after the toggle, so pending=1 and it applies at the following toggle.
- EDGES increments on each rising toggle. If clr_edges and an increment fall in the same cycle, clear wins and EDGES=0.
- CTRL writes update run and clr_edges together.

## Timing
- Reset values:
  - Outputs: clkout=0, tick=0, pending=0, and rd_data reflects the reset registers.
  - State and registers: state=IDLE, cnt=0, run=0, active_half=shadow_half=DEFAULT_HALF, EDGES=0.
- Reset asserted mid-operation returns everything to reset values asynchronously. clkout drops low immediately.
- Start latency: a run=1 write sampled on edge E0 enters RUN at E0. clkout rises at E0+active_half and falls at E0+2*active_half. The period is 2*active_half.
- tick is high for exactly one clkin cycle per clkout rise. It is never asserted in IDLE.
- pending rises on the edge that samples the write and falls on the edge that performs the toggle.
- All outputs except rd_data are registered. rd_data has zero latency.

## Test plan
- Reset, then CTRL=1 with default half 8 → clkout rises 8 cycles after the write and has a period of 16. tick is one cycle wide at each rise. EDGES=4 after 64 cycles.
- While running at half 8, write HALF=3 in cycle 2 of a high phase → that high phase still lasts 8 cycles, pending=1 until the toggle, then phases of 3 cycles. A HALF read returns 3 throughout.
- Write run=0 in cycle 2 of a high phase → clkout stays high 6 more cycles, STATUS.running=1, then IDLE. Write run=0 during a low phase → IDLE on the next edge, clkout stays 0.
- HALF=0 written in IDLE → reads back 1. After run, clkout toggles every cycle and tick occurs every 2 cycles.
- clr_edges in the same cycle as a rising toggle → EDGES=0. With EDGES at max, one more rise → EDGES=0.
- Assert reset while clkout=1 in STOPPING with pending=1 → clkout=0, pending=0, HALF reads 8, state IDLE.

Source files
------------

// File: rtl/clkdiv_ctrl_if.sv
// Register-bus and clock-output bundle for clkdiv_ctrl.
// The master drives writes/read address; the slave returns read data and divider outputs.
interface clkdiv_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [1:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             clkout;
    logic             tick;
    logic             pending;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, clkout, tick, pending
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, clkout, tick, pending
    );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Bus-programmable clock divider: half-period changes and stops are applied only on
// clkout toggle boundaries, so the divided clock never produces a runt pulse.
module clkdiv_ctrl #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEFAULT_HALF = 8
) (
    input  logic          clkin,
    input  logic          reset,
    clkdiv_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    localparam logic [WIDTH-1:0] HALF_RST = WIDTH'(DEFAULT_HALF);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_half;
    logic [WIDTH-1:0] shadow_half;
    logic [WIDTH-1:0] edges;
    logic             run;
    logic             clkout_q;
    logic             tick_q;
    logic             pending_q;

    logic             wr_ctrl;
    logic             wr_half;
    logic             start_req;
    logic             stop_req;
    logic             toggle;
    logic             go_idle;
    logic             rise;
    logic [WIDTH-1:0] half_in;

    assign wr_ctrl   = bus.wr_en && (bus.wr_addr == 2'd0);
    assign wr_half   = bus.wr_en && (bus.wr_addr == 2'd1);
    assign start_req = wr_ctrl && bus.wr_data[0];
    assign stop_req  = wr_ctrl && !bus.wr_data[0];
    assign half_in   = (bus.wr_data == '0) ? WIDTH'(1) : bus.wr_data;
    assign toggle    = (state != IDLE) && (cnt == active_half - WIDTH'(1));

    // A stop during the low phase wins over a coincident rising toggle (low phase truncated).
    assign go_idle = ((state == RUN) && stop_req && (!clkout_q || toggle)) ||
                     ((state == STOPPING) && !start_req && toggle);
    assign rise    = toggle && !clkout_q && !go_idle;

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            run         <= 1'b0;
            clkout_q    <= 1'b0;
            tick_q      <= 1'b0;
            pending_q   <= 1'b0;
            active_half <= HALF_RST;
            shadow_half <= HALF_RST;
            edges       <= '0;
        end else begin
            tick_q <= rise;
            if (wr_ctrl) run <= bus.wr_data[0];

            if (go_idle) begin
                state    <= IDLE;
                cnt      <= '0;
                clkout_q <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= toggle ? '0 : cnt + WIDTH'(1);
                if (toggle) clkout_q <= ~clkout_q;
                if (state == RUN && stop_req) state <= STOPPING;
                else if (state == STOPPING && start_req) state <= RUN;
            end else if (start_req) begin
                state <= RUN;
            end

            // Shadow mirrors active whenever nothing is pending; entering IDLE flushes any pending value.
            if (state == IDLE || go_idle) begin
                pending_q <= 1'b0;
                if (wr_half) begin
                    active_half <= half_in;
                    shadow_half <= half_in;
                end else if (pending_q) begin
                    active_half <= shadow_half;
                end
            end else begin
                if (toggle && pending_q) begin
                    active_half <= shadow_half;
                    pending_q   <= 1'b0;
                end
                if (wr_half) begin
                    shadow_half <= half_in;
                    pending_q   <= 1'b1;
                end
            end

            if (wr_ctrl && bus.wr_data[1]) edges <= '0;
            else if (rise) edges <= edges + WIDTH'(1);
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            2'd0:    bus.rd_data[0] = run;
            2'd1:    bus.rd_data = pending_q ? shadow_half : active_half;
            2'd2:    bus.rd_data[2:0] = {clkout_q, pending_q, state != IDLE};
            default: bus.rd_data = edges;
        endcase
    end

    assign bus.clkout  = clkout_q;
    assign bus.tick    = tick_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: randomized half-periods and stop points checked
// against an arithmetic model of the clkout waveform.
module tb_clkdiv_ctrl;
    localparam int unsigned W = 8;

    logic clkin = 1'b0;
    logic reset = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    clkdiv_ctrl_if #(.WIDTH(W)) bus ();

    clkdiv_ctrl #(.WIDTH(W), .DEFAULT_HALF(8)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Level of clkout n edges after the start edge, half h1; a HALF write of h2 at edge w
    // takes effect at the first h1 toggle strictly after w (h2 == 0: no write).
    function automatic logic exp_clk(input int n, input int h1, input int w, input int h2);
        int t;
        if (h2 == 0 || n < w) return ((n / h1) % 2) != 0;
        t = (w / h1 + 1) * h1;
        if (n < t) return ((n / h1) % 2) != 0;
        return (((t / h1) + (n - t) / h2) % 2) != 0;
    endfunction

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        @(negedge clkin);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clkin);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [W-1:0] d);
        bus.rd_addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic do_reset();
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        reset = 1'b0;
        repeat (2) @(negedge clkin);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        do_reset();
        n_cmp++; if (bus.clkout !== 1'b0) begin n_bad++; $display("FAIL reset_clkout got=%b exp=0", bus.clkout); end
        n_cmp++; if (bus.tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_cmp++;
            if (d !== ((a == 1) ? W'(8) : W'(0))) begin
                n_bad++; $display("FAIL reset_rd addr=%0d got=%0d exp=%0d", a, d, (a == 1) ? 8 : 0);
            end
        end
    endtask

    task automatic test_run_default();
        logic [W-1:0] d;
        logic prev, lv;
        int ecount;
        do_reset();
        wr(2'd0, W'(1));
        prev = 1'b0; ecount = 0;
        for (int n = 1; n <= 64; n++) begin
            step();
            lv = exp_clk(n, 8, 0, 0);
            n_cmp++; if (bus.clkout !== lv) begin n_bad++; $display("FAIL run_clkout n=%0d got=%b exp=%b", n, bus.clkout, lv); end
            n_cmp++; if (bus.tick !== (lv && !prev)) begin n_bad++; $display("FAIL run_tick n=%0d got=%b exp=%b", n, bus.tick, lv && !prev); end
            if (lv && !prev) ecount++;
            prev = lv;
        end
        rd(2'd3, d);
        n_cmp++; if (d !== W'(4) || ecount != 4) begin n_bad++; $display("FAIL run_edges got=%0d exp=4 model=%0d", d, ecount); end
        rd(2'd2, d);
        n_cmp++; if (d[0] !== 1'b1) begin n_bad++; $display("FAIL run_status got=%0d exp_running=1", d); end
    endtask

    task automatic test_half_change();
        logic [W-1:0] d;
        logic lv, prev, ep;
        int h1, h2raw, h2, w, t, nmax;
        for (int it = 0; it < 6; it++) begin
            if (it == 0) begin h1 = 8; h2raw = 3; w = 10; end
            else begin
                h1 = int'($urandom_range(2, 8));
                h2raw = int'($urandom_range(0, 6));
                w = (it == 1) ? 2 * h1 : int'($urandom_range(h1 + 1, 3 * h1));
            end
            h2 = (h2raw == 0) ? 1 : h2raw;
            t = (w / h1 + 1) * h1;
            nmax = t + 4 * h2 + 3;
            do_reset();
            wr(2'd1, W'(h1));
            wr(2'd0, W'(1));
            prev = 1'b0;
            for (int n = 1; n <= nmax; n++) begin
                if (n == w) wr(2'd1, W'(h2raw));
                else step();
                lv = exp_clk(n, h1, w, h2);
                ep = (n >= w) && (n < t);
                n_cmp++; if (bus.clkout !== lv) begin n_bad++; $display("FAIL half_clkout it=%0d n=%0d got=%b exp=%b", it, n, bus.clkout, lv); end
                n_cmp++; if (bus.tick !== (lv && !prev)) begin n_bad++; $display("FAIL half_tick it=%0d n=%0d got=%b exp=%b", it, n, bus.tick, lv && !prev); end
                n_cmp++; if (bus.pending !== ep) begin n_bad++; $display("FAIL half_pending it=%0d n=%0d got=%b exp=%b", it, n, bus.pending, ep); end
                rd(2'd1, d);
                n_cmp++; if (d !== W'((n >= w) ? h2 : h1)) begin n_bad++; $display("FAIL half_read it=%0d n=%0d got=%0d exp=%0d", it, n, d, (n >= w) ? h2 : h1); end
                prev = lv;
            end
        end
    endtask

    task automatic test_stop();
        logic [W-1:0] d;
        logic lv, prev, lvl_before, resume, er;
        int h, ns, n_end;
        for (int it = 0; it < 8; it++) begin
            if (it == 0) begin h = 8; ns = 10; end
            else if (it == 1) begin h = 8; ns = 3; end
            else begin h = int'($urandom_range(1, 6)); ns = int'($urandom_range(1, 4 * h)); end
            lvl_before = exp_clk(ns - 1, h, 0, 0);
            n_end = lvl_before ? ((ns + 2 * h - 1) / (2 * h)) * (2 * h) : ns;
            resume = (it >= 6) && (ns + 1 < n_end);
            if (resume) n_end = 1 << 30;
            do_reset();
            wr(2'd1, W'(h));
            wr(2'd0, W'(1));
            prev = 1'b0;
            for (int n = 1; n <= ns + 2 * h + 3; n++) begin
                if (n == ns) wr(2'd0, W'(0));
                else if (resume && n == ns + 1) wr(2'd0, W'(1));
                else step();
                lv = (n < n_end) ? exp_clk(n, h, 0, 0) : 1'b0;
                er = (n < n_end);
                n_cmp++; if (bus.clkout !== lv) begin n_bad++; $display("FAIL stop_clkout it=%0d n=%0d got=%b exp=%b", it, n, bus.clkout, lv); end
                n_cmp++; if (bus.tick !== (lv && !prev)) begin n_bad++; $display("FAIL stop_tick it=%0d n=%0d got=%b exp=%b", it, n, bus.tick, lv && !prev); end
                rd(2'd2, d);
                n_cmp++; if (d[0] !== er) begin n_bad++; $display("FAIL stop_running it=%0d n=%0d got=%b exp=%b", it, n, d[0], er); end
                prev = lv;
            end
        end
    endtask

    task automatic test_half_zero();
        logic [W-1:0] d;
        do_reset();
        wr(2'd1, W'(0));
        rd(2'd1, d);
        n_cmp++; if (d !== W'(1)) begin n_bad++; $display("FAIL zero_read got=%0d exp=1", d); end
        wr(2'd0, W'(1));
        for (int n = 1; n <= 12; n++) begin
            step();
            n_cmp++; if (bus.clkout !== logic'(n % 2)) begin n_bad++; $display("FAIL zero_clkout n=%0d got=%b exp=%0d", n, bus.clkout, n % 2); end
            n_cmp++; if (bus.tick !== logic'(n % 2)) begin n_bad++; $display("FAIL zero_tick n=%0d got=%b exp=%0d", n, bus.tick, n % 2); end
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] d;
        int h;
        h = int'($urandom_range(2, 5));
        do_reset();
        wr(2'd1, W'(h));
        wr(2'd0, W'(1));
        for (int n = 1; n < 3 * h; n++) step();
        rd(2'd3, d);
        n_cmp++; if (d !== W'(1)) begin n_bad++; $display("FAIL edges_before_clr got=%0d exp=1", d); end
        wr(2'd0, W'(3));
        rd(2'd3, d);
        n_cmp++; if (d !== W'(0)) begin n_bad++; $display("FAIL edges_clr_on_rise got=%0d exp=0", d); end
        n_cmp++; if (bus.tick !== 1'b1) begin n_bad++; $display("FAIL edges_clr_tick got=%b exp=1", bus.tick); end
        for (int n = 3 * h + 1; n <= 5 * h; n++) step();
        rd(2'd3, d);
        n_cmp++; if (d !== W'(1)) begin n_bad++; $display("FAIL edges_after_clr got=%0d exp=1", d); end

        do_reset();
        wr(2'd1, W'(1));
        wr(2'd0, W'(1));
        for (int n = 1; n <= 511; n++) begin
            step();
            if (n == 509 || n == 511) begin
                rd(2'd3, d);
                n_cmp++;
                if (d !== W'(((n + 1) / 2) % 256)) begin
                    n_bad++; $display("FAIL edges_wrap n=%0d got=%0d exp=%0d", n, d, ((n + 1) / 2) % 256);
                end
            end
        end
    endtask

    task automatic test_reset_stopping();
        logic [W-1:0] d;
        do_reset();
        wr(2'd0, W'(1));
        for (int n = 1; n < 10; n++) step();
        wr(2'd1, W'(5));
        wr(2'd0, W'(0));
        rd(2'd2, d);
        n_cmp++; if (d !== W'(7)) begin n_bad++; $display("FAIL stopping_status got=%0d exp=7", d); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.clkout !== 1'b0) begin n_bad++; $display("FAIL areset_clkout got=%b exp=0", bus.clkout); end
        n_cmp++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL areset_pending got=%b exp=0", bus.pending); end
        rd(2'd1, d);
        n_cmp++; if (d !== W'(8)) begin n_bad++; $display("FAIL areset_half got=%0d exp=8", d); end
        rd(2'd2, d);
        n_cmp++; if (d !== W'(0)) begin n_bad++; $display("FAIL areset_status got=%0d exp=0", d); end
        @(negedge clkin);
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (bus.clkout !== 1'b0 || bus.tick !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset clkout=%b tick=%b exp=0/0", bus.clkout, bus.tick); end
    endtask

    initial begin
        test_reset();
        test_run_default();
        test_half_change();
        test_stop();
        test_half_zero();
        test_edges();
        test_reset_stopping();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
